// File: rtl/psram_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// psram_access_arbiter_if
//
// Bundles everything between the PSRAM access arbiter and its neighbours:
// the reader and writer request/ack pairs, the controller command port and
// the status outputs.
//
// Handshake: a requester holds rq (level) with a stable address until the
// arbiter answers with a one-cycle ack pulse; the requester drops rq no later
// than the cycle after the ack. An rq still high when the arbiter next
// arbitrates counts as a fresh request. mem_cmd_en is a single-cycle strobe
// with mem_cmd/mem_addr valid in that cycle; the controller has no
// backpressure on it.
//
// Modports:
//   master - the arbiter (drives acks, command port, status)
//   slave  - requesters plus controller (drive rq/addr, ready, read valid)
// state_dbg exposes the arbiter FSM state for checkers.
// ---------------------------------------------------------------------------
interface psram_access_arbiter_if;
   logic        mem_ready;
   logic        rd_rq;
   logic [20:0] rd_addr;
   logic        rd_ack;
   logic        wr_rq;
   logic [20:0] wr_addr;
   logic        wr_ack;
   logic        wr_data_req;
   logic        mem_cmd;
   logic        mem_cmd_en;
   logic [20:0] mem_addr;
   logic        mem_rd_data_valid;
   logic        busy;
   logic        rd_timeout_err;
   logic [2:0]  state_dbg;

   modport master (
      input  mem_ready, rd_rq, rd_addr, wr_rq, wr_addr, mem_rd_data_valid,
      output rd_ack, wr_ack, wr_data_req, mem_cmd, mem_cmd_en, mem_addr,
             busy, rd_timeout_err, state_dbg
   );

   modport slave (
      output mem_ready, rd_rq, rd_addr, wr_rq, wr_addr, mem_rd_data_valid,
      input  rd_ack, wr_ack, wr_data_req, mem_cmd, mem_cmd_en, mem_addr,
             busy, rd_timeout_err, state_dbg
   );
endinterface

// File: rtl/psram_access_arbiter.sv
// ---------------------------------------------------------------------------
// psram_access_arbiter
//
// Shares one PSRAM controller command port between a burst writer (camera
// uploader) and a burst reader (frame downloader). Writes win arbitration,
// but while a read is pending at most MAX_WR_STREAK writes are granted in a
// row. Every transaction is followed by CMD_GAP idle cycles. A read that
// does not deliver its BURST_CYCLES beats within RD_TIMEOUT cycles of its
// command strobe is abandoned and raises a sticky error.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - psram_access_arbiter_if.master (requests, acks, command
//              port, busy, rd_timeout_err, state_dbg)
// ---------------------------------------------------------------------------
module psram_access_arbiter #(
   parameter int MEMORY_BURST  = 32,
   parameter int CMD_GAP       = 15,
   parameter int MAX_WR_STREAK = 4,
   parameter int RD_TIMEOUT    = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   psram_access_arbiter_if.master bus
);

   localparam int BURST_CYCLES = MEMORY_BURST / 4;
   localparam int CNT_MAX      = (BURST_CYCLES > CMD_GAP) ? BURST_CYCLES : CMD_GAP;
   localparam int CW           = $clog2(CNT_MAX + 1);
   localparam int BW           = $clog2(BURST_CYCLES + 1);
   localparam int TW           = $clog2(RD_TIMEOUT + 1);
   localparam int SW           = $clog2(MAX_WR_STREAK + 1);
   // The timeout counter is cleared in the command cycle and reads k-1 in
   // the k-th RD_WAIT cycle, so the last cycle in which a final beat is still
   // accepted (command cycle + RD_TIMEOUT - 1) sees RD_TIMEOUT - 2.
   localparam int TO_LAST      = RD_TIMEOUT - 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARB      = 3'd1,
      RD_ISSUE = 3'd2,
      RD_WAIT  = 3'd3,
      WR_ISSUE = 3'd4,
      WR_DATA  = 3'd5,
      GAP      = 3'd6
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;          // WR_DATA beat / GAP cycle counter
   logic [BW-1:0] beat_cnt, beat_nxt;    // read beats received
   logic [TW-1:0] to_cnt, to_nxt;        // read timeout counter
   logic [SW-1:0] streak, streak_nxt;    // consecutive writes while reads wait
   logic [20:0]   addr_q, addr_nxt;
   logic          err_q, err_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         beat_cnt <= '0;
         to_cnt   <= '0;
         streak   <= '0;
         addr_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         beat_cnt <= beat_nxt;
         to_cnt   <= to_nxt;
         streak   <= streak_nxt;
         addr_q   <= addr_nxt;
         err_q    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = '0;
      beat_nxt   = beat_cnt;
      to_nxt     = to_cnt;
      streak_nxt = streak;
      addr_nxt   = addr_q;
      err_nxt    = err_q;

      case (state)
         IDLE: begin
            if (bus.mem_ready) state_nxt = ARB;
         end
         ARB: begin
            if (!bus.mem_ready) begin
               state_nxt = IDLE;
            end else if (bus.wr_rq && (!bus.rd_rq || (streak < SW'(MAX_WR_STREAK)))) begin
               addr_nxt  = bus.wr_addr;
               state_nxt = WR_ISSUE;
               if (!bus.rd_rq)
                  streak_nxt = '0;
               else if (streak != SW'(MAX_WR_STREAK))
                  streak_nxt = streak + SW'(1);
            end else if (bus.rd_rq) begin
               addr_nxt   = bus.rd_addr;
               state_nxt  = RD_ISSUE;
               streak_nxt = '0;
            end
         end
         RD_ISSUE: begin
            beat_nxt  = '0;
            to_nxt    = '0;
            state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            to_nxt = to_cnt + TW'(1);
            if (bus.mem_rd_data_valid) beat_nxt = beat_cnt + BW'(1);
            // A final beat in the last allowed cycle beats the timeout.
            if (bus.mem_rd_data_valid && (beat_cnt == BW'(BURST_CYCLES - 1))) begin
               state_nxt = GAP;
            end else if (to_cnt == TW'(TO_LAST)) begin
               err_nxt   = 1'b1;
               state_nxt = GAP;
            end
         end
         WR_ISSUE: begin
            state_nxt = WR_DATA;
         end
         WR_DATA: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(BURST_CYCLES - 1)) state_nxt = GAP;
         end
         GAP: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(CMD_GAP - 1)) state_nxt = ARB;
         end
         default: state_nxt = IDLE;
      endcase

      // Every state starts counting from zero.
      if (state_nxt != state) cnt_nxt = '0;
   end

   // Outputs decode the registered state, so an asynchronous reset drops
   // them immediately.
   assign bus.rd_ack         = (state == RD_ISSUE);
   assign bus.wr_ack         = (state == WR_ISSUE);
   assign bus.wr_data_req    = (state == WR_DATA);
   assign bus.mem_cmd        = (state == WR_DATA) && (cnt == '0);
   assign bus.mem_cmd_en     = (state == RD_ISSUE) || ((state == WR_DATA) && (cnt == '0));
   assign bus.mem_addr       = addr_q;
   assign bus.busy           = (state != IDLE) && (state != ARB);
   assign bus.rd_timeout_err = err_q;
   assign bus.state_dbg      = state;

endmodule
